// File: rtl/wave_capture_multi_pkg.sv
// Shared types and helpers for the multi-channel wave capture stage.
package wave_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    localparam logic [1:0] TRIG_FREE = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;

    // Top ow bits of a signed sw-bit sample with the MSB inverted (truncation, no rounding); sw <= 32.
    function automatic logic [31:0] to_offset_binary(input logic [31:0] s, input int sw, input int ow);
        logic [31:0] r;
        r = s >> (sw - ow);
        r = r ^ (32'd1 << (ow - 1));
        return r;
    endfunction

endpackage

// File: rtl/wave_trigger_detect.sv
// Zero-cross / free-run trigger on one selectable channel; fire is a same-cycle pulse per qualifying strobe.
module wave_trigger_detect
    import wave_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int CH_W = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            strobe,
    input  logic [NCH-1:0]  cur_sign,
    input  logic [1:0]      trig_mode,
    input  logic [CH_W-1:0] trig_channel,
    output logic            fire
);

    // Zero-crossing only depends on the sign, so only the sign of each channel is remembered.
    logic [NCH-1:0]  prev_sign_reg;
    logic [CH_W-1:0] sel;
    logic            prev_neg;
    logic            cur_neg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sign_reg <= '0;
        end else if (strobe) begin
            prev_sign_reg <= cur_sign;
        end
    end

    always_comb begin
        sel      = (32'(trig_channel) < NCH) ? trig_channel : '0;
        prev_neg = prev_sign_reg[sel];
        cur_neg  = cur_sign[sel];
        case (trig_mode)
            TRIG_RISE: fire = strobe && prev_neg && !cur_neg;
            TRIG_FALL: fire = strobe && !prev_neg && cur_neg;
            default:   fire = strobe;
        endcase
    end

endmodule

// File: rtl/wave_capture_multi.sv
// NCH-channel ping-pong capture into the scope RAM with trigger, decimation and overrun detection.
module wave_capture_multi
    import wave_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int SW    = 16,
    parameter int OUT_W = 8,
    parameter int DEPTH = 8,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [NCH*SW-1:0]       new_sample_in,
    input  logic [1:0]              trig_mode,
    input  logic [CH_W-1:0]         trig_channel,
    input  logic [3:0]              decim,
    input  logic                    wave_display_idle,
    output logic                    write_enable,
    output logic [CH_W+DEPTH:0]     write_address,
    output logic [OUT_W-1:0]        write_sample,
    output logic                    read_index,
    output logic                    busy,
    output logic                    overrun
);

    state_t              state_reg, state_next;
    logic                seq_active_reg;
    logic [CH_W-1:0]     seq_ch_reg;
    logic [DEPTH-1:0]    sample_index_reg;
    logic [NCH*SW-1:0]   samples_reg;
    logic [3:0]          decim_latched_reg;
    logic [3:0]          decim_cnt_reg;
    logic                read_index_reg;
    logic                overrun_reg;

    logic [NCH-1:0]      cur_sign;
    logic [SW-1:0]       ch_sample [NCH];
    logic                fire;
    logic                accept;
    logic                drop;
    logic                last_write;
    logic                wrap;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign cur_sign[gi]  = new_sample_in[gi*SW + SW-1];
            assign ch_sample[gi] = samples_reg[gi*SW +: SW];
        end
    endgenerate

    wave_trigger_detect #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_trig (
        .clk          (clk),
        .reset        (reset),
        .strobe       (new_sample_ready),
        .cur_sign     (cur_sign),
        .trig_mode    (trig_mode),
        .trig_channel (trig_channel),
        .fire         (fire)
    );

    assign accept     = new_sample_ready && !seq_active_reg &&
                        ((state_reg == ST_ARMED && fire) ||
                         (state_reg == ST_CAPTURE && decim_cnt_reg == 4'd0));
    assign drop       = new_sample_ready && seq_active_reg;
    assign last_write = seq_active_reg && (seq_ch_reg == CH_W'(NCH-1));
    assign wrap       = last_write && (sample_index_reg == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_ARMED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARMED:   if (accept)            state_next = ST_CAPTURE;
            ST_CAPTURE: if (wrap)              state_next = ST_WAIT;
            ST_WAIT:    if (wave_display_idle) state_next = ST_ARMED;
            default:                           state_next = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_active_reg    <= 1'b0;
            seq_ch_reg        <= '0;
            sample_index_reg  <= '0;
            samples_reg       <= '0;
            decim_latched_reg <= '0;
            decim_cnt_reg     <= '0;
            read_index_reg    <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            if (accept) begin
                samples_reg    <= new_sample_in;
                seq_active_reg <= 1'b1;
                seq_ch_reg     <= '0;
            end else if (seq_active_reg) begin
                if (last_write) begin
                    seq_active_reg   <= 1'b0;
                    seq_ch_reg       <= '0;
                    sample_index_reg <= sample_index_reg + 1'b1;
                end else begin
                    seq_ch_reg <= seq_ch_reg + 1'b1;
                end
            end

            // The triggering strobe is count 0, so the counter resumes at 1 unless every sample is kept.
            if (state_reg == ST_ARMED && accept) begin
                decim_latched_reg <= decim;
                decim_cnt_reg     <= (decim == 4'd0) ? 4'd0 : 4'd1;
            end else if (state_reg == ST_CAPTURE && new_sample_ready && !seq_active_reg) begin
                decim_cnt_reg <= (decim_cnt_reg == decim_latched_reg) ? 4'd0 : decim_cnt_reg + 4'd1;
            end

            if (state_reg == ST_WAIT && wave_display_idle) begin
                read_index_reg <= ~read_index_reg;
            end

            if (drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign write_enable  = seq_active_reg;
    assign write_address = seq_active_reg ? {~read_index_reg, seq_ch_reg, sample_index_reg} : '0;
    assign write_sample  = seq_active_reg ?
                           OUT_W'(to_offset_binary(32'(ch_sample[seq_ch_reg]), SW, OUT_W)) : '0;
    assign read_index    = read_index_reg;
    assign busy          = (state_reg == ST_CAPTURE) || seq_active_reg;
    assign overrun       = overrun_reg;

endmodule
